// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, issues fetches and fills the IF/ID register.
// Takes ID redirects with a single delay slot, a load-use stall and a variable-latency memory.
module stage_if (
    input  logic        clock,
    input  logic        reset_0,
    input  logic [31:0] pc_b,
    input  logic [31:0] pc_j,
    input  logic [31:0] a_id,
    input  logic [1:0]  pc_select,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4_id,
    output logic [31:0] instr_id,
    output logic        valid_id
);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        pending_q, pending_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] sel_target;
    logic [31:0] next_pc;
    logic        accept;
    logic [31:0] accept_word;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        sel_target = pc_plus4;
        unique case (pc_select)
            2'b00: sel_target = pc_plus4;
            2'b01: sel_target = pc_b;
            2'b10: sel_target = a_id;
            2'b11: sel_target = pc_j;
            default: sel_target = pc_plus4;
        endcase
    end

    // A latched redirect wins; pc_select is only meaningful while ID holds a real instruction.
    assign next_pc = pending_q ? target_q : (valid_q ? sel_target : pc_plus4);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        pending_d   = pending_q;
        buf_d       = buf_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        accept      = 1'b0;
        accept_word = imem_rdata;

        unique case (state_q)
            StRun: begin
                if (stall) begin
                    if (imem_ready) begin
                        buf_d   = imem_rdata;
                        state_d = StHold;
                    end
                end else if (imem_ready) begin
                    accept = 1'b1;
                end else begin
                    instr_d = 32'd0;
                    valid_d = 1'b0;
                    // ID's redirect would be lost once the bubble replaces it, so keep it.
                    if (valid_q && (pc_select != 2'b00)) begin
                        pending_d = 1'b1;
                        target_d  = sel_target;
                    end
                end
            end
            StHold: begin
                if (!stall) begin
                    accept      = 1'b1;
                    accept_word = buf_q;
                    state_d     = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (accept) begin
            pc4_d     = pc_plus4;
            instr_d   = accept_word;
            valid_d   = 1'b1;
            pc_d      = next_pc;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q   <= StRun;
            pc_q      <= 32'd0;
            target_q  <= 32'd0;
            pending_q <= 1'b0;
            buf_q     <= 32'd0;
            instr_q   <= 32'd0;
            pc4_q     <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            target_q  <= target_d;
            pending_q <= pending_d;
            buf_q     <= buf_d;
            instr_q   <= instr_d;
            pc4_q     <= pc4_d;
            valid_q   <= valid_d;
        end
    end

    assign imem_req  = (state_q == StRun);
    assign imem_addr = pc_q;
    assign pc4_id    = pc4_q;
    assign instr_id  = instr_q;
    assign valid_id  = valid_q;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed scenarios against constants, then random traffic against
// a fetch-transaction reference model.
module tb_stage_if;

    logic        clock = 1'b0;
    logic        reset_0 = 1'b0;
    logic [31:0] pc_b = '0, pc_j = '0, a_id = '0;
    logic [1:0]  pc_select = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata;
    logic [31:0] pc4_id, instr_id;
    logic        valid_id;
    logic [31:0] junk = '0;

    int n_cmp = 0;
    int n_err = 0;

    stage_if dut (
        .clock      (clock),
        .reset_0    (reset_0),
        .pc_b       (pc_b),
        .pc_j       (pc_j),
        .a_id       (a_id),
        .pc_select  (pc_select),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc4_id     (pc4_id),
        .instr_id   (instr_id),
        .valid_id   (valid_id)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory returns an address-tagged word; junk perturbs it to expose stale captures.
    assign imem_rdata = tag(imem_addr) ^ junk;

    function automatic logic [97:0] pack(input logic r, input logic [31:0] a,
                                         input logic [31:0] p4, input logic [31:0] ins,
                                         input logic v);
        return {r, a, p4, ins, v};
    endfunction

    logic [97:0] obs;
    assign obs = {imem_req, imem_addr, pc4_id, instr_id, valid_id};

    // Reference model: what ID holds, where the next fetch goes, and any word parked by a stall.
    logic [31:0] m_pc, m_pc4, m_instr, m_parked, m_redirect;
    logic        m_valid, m_parked_ok, m_redirect_ok;

    function automatic logic [97:0] model_obs();
        return pack(!m_parked_ok, m_pc, m_pc4, m_instr, m_valid);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_pc4 = 0; m_instr = 0; m_parked = 0; m_redirect = 0;
        m_valid = 0; m_parked_ok = 0; m_redirect_ok = 0;
    endtask

    task automatic step();
        logic [31:0] choice, dest, word;
        logic        deliver;
        case (pc_select)
            2'b00: choice = m_pc + 32'd4;
            2'b01: choice = pc_b;
            2'b10: choice = a_id;
            default: choice = pc_j;
        endcase
        if (m_redirect_ok) dest = m_redirect;
        else if (m_valid) dest = choice;
        else dest = m_pc + 32'd4;
        deliver = 0;
        word = 0;
        @(posedge clock);
        if (m_parked_ok) begin
            if (!stall) begin deliver = 1; word = m_parked; m_parked_ok = 0; end
        end else if (stall) begin
            if (imem_ready) begin m_parked = tag(m_pc) ^ junk; m_parked_ok = 1; end
        end else if (imem_ready) begin
            deliver = 1; word = tag(m_pc) ^ junk;
        end else begin
            if (m_valid && pc_select != 2'b00) begin
                m_redirect = choice; m_redirect_ok = 1;
            end
            m_instr = 0; m_valid = 0;
        end
        if (deliver) begin
            m_pc4 = m_pc + 32'd4; m_instr = word; m_valid = 1;
            m_pc = dest; m_redirect_ok = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        #2 reset_0 = 1'b0;
        model_reset();
        stall = 0; imem_ready = 1; pc_select = 0; junk = 0;
        #4 reset_0 = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (obs !== pack(1, 0, 0, 0, 0)) begin
            n_err++; $display("FAIL reset: got %h want %h", obs, pack(1, 0, 0, 0, 0));
        end
    endtask

    task automatic test_straight();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step();
            n_cmp++;
            if (obs !== pack(1, 4 * k, 4 * k, tag(4 * (k - 1)), 1)) begin
                n_err++;
                $display("FAIL straight[%0d]: got %h want %h", k, obs,
                         pack(1, 4 * k, 4 * k, tag(4 * (k - 1)), 1));
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        step(); step();
        pc_select = 2'b01; pc_b = 32'h100;
        step();
        n_cmp++;
        if (obs !== pack(1, 32'h100, 32'hC, tag(8), 1)) begin
            n_err++; $display("FAIL branch_slot: got %h want %h", obs,
                              pack(1, 32'h100, 32'hC, tag(8), 1));
        end
        pc_select = 2'b00;
        step();
        n_cmp++;
        if (obs !== pack(1, 32'h104, 32'h104, tag(32'h100), 1)) begin
            n_err++; $display("FAIL branch_target: got %h want %h", obs,
                              pack(1, 32'h104, 32'h104, tag(32'h100), 1));
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        step();
        pc_select = 2'b11; pc_j = 32'h400; imem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            pc_select = 2'b01; pc_b = 32'h9990;
            n_cmp++;
            if (obs !== pack(1, 4, 4, 0, 0)) begin
                n_err++; $display("FAIL wait_bubble[%0d]: got %h want %h", k, obs,
                                  pack(1, 4, 4, 0, 0));
            end
        end
        imem_ready = 1;
        step();
        n_cmp++;
        if (obs !== pack(1, 32'h400, 8, tag(4), 1)) begin
            n_err++; $display("FAIL wait_redirect: got %h want %h", obs,
                              pack(1, 32'h400, 8, tag(4), 1));
        end
        pc_select = 2'b00;
    endtask

    task automatic test_stall_ready();
        do_reset();
        for (int k = 0; k < 8; k++) step();
        stall = 1; junk = 32'h00A5_5A00;
        step();
        junk = 32'h1234_0000;
        n_cmp++;
        if (obs !== pack(0, 32'h20, 32'h20, tag(32'h1C), 1)) begin
            n_err++; $display("FAIL hold_enter: got %h want %h", obs,
                              pack(0, 32'h20, 32'h20, tag(32'h1C), 1));
        end
        step();
        n_cmp++;
        if (obs !== pack(0, 32'h20, 32'h20, tag(32'h1C), 1)) begin
            n_err++; $display("FAIL hold_keep: got %h want %h", obs,
                              pack(0, 32'h20, 32'h20, tag(32'h1C), 1));
        end
        stall = 0;
        step();
        n_cmp++;
        if (obs !== pack(1, 32'h24, 32'h24, tag(32'h20) ^ 32'h00A5_5A00, 1)) begin
            n_err++; $display("FAIL hold_release: got %h want %h", obs,
                              pack(1, 32'h24, 32'h24, tag(32'h20) ^ 32'h00A5_5A00, 1));
        end
        junk = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        stall = 1;
        step();
        n_cmp++;
        if (obs !== pack(0, 4, 4, tag(0), 1)) begin
            n_err++; $display("FAIL areset_hold: got %h want %h", obs, pack(0, 4, 4, tag(0), 1));
        end
        #2 reset_0 = 1'b0;
        #1;
        n_cmp++;
        if (obs !== pack(1, 0, 0, 0, 0)) begin
            n_err++; $display("FAIL areset_immediate: got %h want %h", obs, pack(1, 0, 0, 0, 0));
        end
        model_reset();
        #2 reset_0 = 1'b1;
        stall = 0;
        step();
        n_cmp++;
        if (obs !== pack(1, 4, 4, tag(0), 1)) begin
            n_err++; $display("FAIL areset_refetch: got %h want %h", obs, pack(1, 4, 4, tag(0), 1));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step();
        pc_select = 2'b11; pc_j = 32'hFFFF_FFFC;
        step();
        pc_select = 2'b00;
        step();
        n_cmp++;
        if (obs !== pack(1, 0, 0, tag(32'hFFFF_FFFC), 1)) begin
            n_err++; $display("FAIL wrap: got %h want %h", obs,
                              pack(1, 0, 0, tag(32'hFFFF_FFFC), 1));
        end
        step();
        n_cmp++;
        if (obs !== pack(1, 4, 4, tag(0), 1)) begin
            n_err++; $display("FAIL wrap_next: got %h want %h", obs, pack(1, 4, 4, tag(0), 1));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            stall      = ($urandom_range(0, 99) < 30);
            imem_ready = ($urandom_range(0, 99) < 65);
            pc_select  = 2'($urandom_range(0, 3));
            pc_b       = $urandom & 32'hFFFF_FFFC;
            pc_j       = $urandom & 32'hFFFF_FFFC;
            a_id       = $urandom & 32'hFFFF_FFFC;
            junk       = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
            step();
            n_cmp++;
            if (obs !== model_obs()) begin
                n_err++; $display("FAIL random[%0d]: got %h want %h", k, obs, model_obs());
            end
        end
    endtask

    initial begin
        model_reset();
        #12 reset_0 = 1'b1;
        #1;
        test_reset();
        test_straight();
        test_branch();
        test_redirect_wait();
        test_stall_ready();
        test_async_reset();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
